// File: rtl/adc_multich_capture.sv
// Multi-channel ADC frame capture: serializes NUM_CH-wide frames into
// channel-tagged 16-bit words and buffers them in a FIFO for host readback.
module adc_multich_capture #(
    parameter int PRECISION       = 10,
    parameter int NUM_CH          = 4,
    parameter int CH_BITS         = 2,
    parameter int FIFO_ADDR_WIDTH = 10
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sample_valid,
    input  logic [NUM_CH*PRECISION-1:0]   sample_data,
    input  logic                          arm,
    input  logic                          stop,
    input  logic                          mode,
    input  logic [7:0]                    decim,
    input  logic [15:0]                   capture_len,
    input  logic                          rd_en,
    output logic [15:0]                   rd_data,
    output logic [FIFO_ADDR_WIDTH:0]      rd_count,
    output logic                          empty,
    output logic                          busy,
    output logic                          done,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int CW    = FIFO_ADDR_WIDTH + 1;
    localparam int DEPTH = 1 << FIFO_ADDR_WIDTH;
    localparam logic [CW-1:0]      DEPTH_C = CW'(DEPTH);
    localparam logic [CH_BITS-1:0] LAST_CH = CH_BITS'(NUM_CH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_SERIALIZE,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic                         mode_r;
    logic [7:0]                   decim_r;
    logic [15:0]                  cap_len_r;
    logic [7:0]                   decim_cnt;
    logic [16:0]                  frame_cnt;
    logic [16:0]                  frame_cnt_inc;
    logic [16:0]                  frame_target;
    logic [NUM_CH*PRECISION-1:0]  hold;
    logic [CH_BITS-1:0]           ch_idx;
    logic                         stop_seen;

    logic                         do_arm;
    logic                         do_capture;
    logic                         do_skip;
    logic                         frame_end;

    logic [15:0]                  mem [DEPTH];
    logic [FIFO_ADDR_WIDTH-1:0]   wr_ptr;
    logic [FIFO_ADDR_WIDTH-1:0]   rd_ptr;
    logic [CW-1:0]                count;
    logic                         wr_req;
    logic                         wr_ok;
    logic                         rd_valid;
    logic [15:0]                  wr_word;

    assign frame_cnt_inc = frame_cnt + 17'd1;
    assign frame_target  = {(cap_len_r == 16'd0), cap_len_r};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        do_arm     = 1'b0;
        do_capture = 1'b0;
        do_skip    = 1'b0;
        frame_end  = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (arm) begin
                    do_arm    = 1'b1;
                    state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (stop) begin
                    state_nxt = S_IDLE;
                end else if (sample_valid) begin
                    if (decim_cnt == 8'd0) begin
                        do_capture = 1'b1;
                        state_nxt  = S_SERIALIZE;
                    end else begin
                        do_skip = 1'b1;
                    end
                end
            end
            S_SERIALIZE: begin
                // A stop on the final word cycle still counts as seen.
                if (ch_idx == LAST_CH) begin
                    frame_end = 1'b1;
                    if (!mode_r && (frame_cnt_inc == frame_target)) begin
                        state_nxt = S_DONE;
                    end else if (stop_seen || stop) begin
                        state_nxt = S_IDLE;
                    end else begin
                        state_nxt = S_CAPTURE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        wr_word                  = '0;
        wr_word[15:12]           = 4'(ch_idx);
        wr_word[PRECISION-1:0]   = hold[PRECISION-1:0];
    end

    assign wr_req   = (state == S_SERIALIZE);
    assign rd_valid = rd_en && (count != '0);
    assign wr_ok    = wr_req && ((count < DEPTH_C) || rd_valid);

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_r    <= 1'b0;
            decim_r   <= '0;
            cap_len_r <= '0;
            decim_cnt <= '0;
            frame_cnt <= '0;
            hold      <= '0;
            ch_idx    <= '0;
            stop_seen <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rd_data   <= '0;
        end else begin
            if (do_arm) begin
                mode_r    <= mode;
                decim_r   <= decim;
                cap_len_r <= capture_len;
                decim_cnt <= '0;
                frame_cnt <= '0;
                stop_seen <= 1'b0;
                overflow  <= 1'b0;
                underflow <= 1'b0;
            end

            if (do_capture) begin
                hold      <= sample_data;
                decim_cnt <= decim_r;
                ch_idx    <= '0;
            end

            if (do_skip) begin
                decim_cnt <= decim_cnt - 8'd1;
            end

            // The holding register shifts down so channel ch_idx is always in the low slot.
            if (state == S_SERIALIZE) begin
                hold   <= hold >> PRECISION;
                ch_idx <= ch_idx + CH_BITS'(1);
                if (stop) begin
                    stop_seen <= 1'b1;
                end
                if (sample_valid) begin
                    overflow <= 1'b1;
                end
            end

            if (frame_end) begin
                frame_cnt <= frame_cnt_inc;
                stop_seen <= 1'b0;
            end

            if (wr_ok) begin
                wr_ptr <= wr_ptr + FIFO_ADDR_WIDTH'(1);
            end else if (wr_req) begin
                overflow <= 1'b1;
            end

            if (rd_valid) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + FIFO_ADDR_WIDTH'(1);
            end else if (rd_en) begin
                rd_data   <= 16'h0000;
                underflow <= 1'b1;
            end

            if (wr_ok && !rd_valid) begin
                count <= count + CW'(1);
            end else if (!wr_ok && rd_valid) begin
                count <= count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_word;
        end
    end

    assign rd_count = count;
    assign empty    = (count == '0);
    assign busy     = (state == S_CAPTURE) || (state == S_SERIALIZE);
    assign done     = (state == S_DONE);

endmodule

// File: tb/tb_adc_multich_capture.sv
// Scoreboard bench for adc_multich_capture: expected words are queued as
// frames are driven and compared as they are read back from the FIFO.
module tb_adc_multich_capture;

    localparam int PRECISION = 10;
    localparam int NUM_CH    = 4;
    localparam int CH_BITS   = 2;
    localparam int AW        = 4;
    localparam int DEPTH     = 1 << AW;

    logic                         clk = 1'b0;
    logic                         rst;
    logic                         sample_valid;
    logic [NUM_CH*PRECISION-1:0]  sample_data;
    logic                         arm;
    logic                         stop;
    logic                         mode;
    logic [7:0]                   decim;
    logic [15:0]                  capture_len;
    logic                         rd_en;
    logic [15:0]                  rd_data;
    logic [AW:0]                  rd_count;
    logic                         empty;
    logic                         busy;
    logic                         done;
    logic                         overflow;
    logic                         underflow;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    adc_multich_capture #(
        .PRECISION(PRECISION),
        .NUM_CH(NUM_CH),
        .CH_BITS(CH_BITS),
        .FIFO_ADDR_WIDTH(AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sample_valid(sample_valid),
        .sample_data(sample_data),
        .arm(arm),
        .stop(stop),
        .mode(mode),
        .decim(decim),
        .capture_len(capture_len),
        .rd_en(rd_en),
        .rd_data(rd_data),
        .rd_count(rd_count),
        .empty(empty),
        .busy(busy),
        .done(done),
        .overflow(overflow),
        .underflow(underflow)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [15:0] exp_word(input int ch, input logic [9:0] code);
        return {4'(ch), 2'b00, code};
    endfunction

    task automatic do_arm(input logic m, input logic [7:0] d, input logic [15:0] len);
        mode        = m;
        decim       = d;
        capture_len = len;
        arm         = 1'b1;
        tick();
        arm         = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    // Frame where channel k carries base+k; keep selects which words should land in the FIFO.
    task automatic applyStimulus(input logic [9:0] base, input logic [3:0] keep);
        for (int k = 0; k < NUM_CH; k++) begin
            sample_data[k*PRECISION +: PRECISION] = base + 10'(k);
            if (keep[k]) exp_q.push_back(exp_word(k, base + 10'(k)));
        end
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic read_word(input string tag);
        logic [15:0] e;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        if (exp_q.size() == 0) begin
            checkOutput({tag, "_unexpected"}, 32'(rd_data), 32'hDEAD_BEEF);
        end else begin
            e = exp_q.pop_front();
            checkOutput(tag, 32'(rd_data), 32'(e));
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [15:0] e;
        rst = 1'b1; sample_valid = 1'b0; sample_data = '0; arm = 1'b0; stop = 1'b0;
        mode = 1'b0; decim = '0; capture_len = '0; rd_en = 1'b0;
        tick(2);
        rst = 1'b0;
        checkOutput("rst_count", 32'(rd_count), 0);
        checkOutput("rst_empty", 32'(empty), 1);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_done", 32'(done), 0);
        checkOutput("rst_ovf", 32'(overflow), 0);
        checkOutput("rst_udf", 32'(underflow), 0);
        checkOutput("rst_rdata", 32'(rd_data), 0);

        // Single-shot, two frames
        do_arm(1'b0, 8'd0, 16'd2);
        checkOutput("ss_busy_armed", 32'(busy), 1);
        applyStimulus(10'd1, 4'hF);
        tick(5);
        applyStimulus(10'd5, 4'hF);
        tick(6);
        checkOutput("ss_count", 32'(rd_count), 8);
        checkOutput("ss_done", 32'(done), 1);
        checkOutput("ss_busy", 32'(busy), 0);
        for (int i = 0; i < 8; i++) read_word("ss_read");
        checkOutput("ss_empty", 32'(empty), 1);

        // Continuous with decimation: keep frames 0, 3, 6
        do_arm(1'b1, 8'd2, 16'd0);
        for (int i = 0; i < 9; i++) begin
            applyStimulus(10'(16 * i + 32), (i % 3 == 0) ? 4'hF : 4'h0);
            tick(7);
        end
        checkOutput("dec_count", 32'(rd_count), 12);
        checkOutput("dec_busy", 32'(busy), 1);
        pulse_stop();
        checkOutput("dec_stop_busy", 32'(busy), 0);
        checkOutput("dec_stop_done", 32'(done), 0);
        for (int i = 0; i < 12; i++) read_word("dec_read");
        checkOutput("dec_empty", 32'(empty), 1);

        // Second frame arrives while the first serializes
        do_arm(1'b1, 8'd0, 16'd0);
        applyStimulus(10'h100, 4'hF);
        applyStimulus(10'h200, 4'h0);
        tick(6);
        checkOutput("ser_ovf", 32'(overflow), 1);
        checkOutput("ser_count", 32'(rd_count), 4);
        pulse_stop();
        for (int i = 0; i < 4; i++) read_word("ser_read");
        do_arm(1'b1, 8'd0, 16'd0);
        checkOutput("ser_rearm_ovf", 32'(overflow), 0);
        pulse_stop();
        checkOutput("ser_idle_busy", 32'(busy), 0);

        // FIFO full: four frames fit, the fifth is dropped entirely
        do_arm(1'b1, 8'd0, 16'd0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(10'(10'h300 + 8 * i), (i < 4) ? 4'hF : 4'h0);
            tick(5);
        end
        checkOutput("full_count", 32'(rd_count), DEPTH);
        checkOutput("full_ovf", 32'(overflow), 1);
        applyStimulus(10'h340, 4'h0);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        e = exp_q.pop_front();
        checkOutput("full_rdwr_data", 32'(rd_data), 32'(e));
        exp_q.push_back(exp_word(0, 10'h340));
        checkOutput("full_rdwr_count", 32'(rd_count), DEPTH);
        tick(4);
        pulse_stop();
        checkOutput("full_stop_busy", 32'(busy), 0);
        for (int i = 0; i < DEPTH; i++) read_word("full_read");
        checkOutput("full_drain_empty", 32'(empty), 1);
        checkOutput("full_drain_count", 32'(rd_count), 0);

        // Read while empty
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checkOutput("udf_rdata", 32'(rd_data), 0);
        checkOutput("udf_flag", 32'(underflow), 1);
        checkOutput("udf_count", 32'(rd_count), 0);

        // Reset in the middle of serializing a frame
        do_arm(1'b1, 8'd0, 16'd0);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        applyStimulus(10'h050, 4'h0);
        tick(2);
        checkOutput("mid_count", 32'(rd_count), 2);
        checkOutput("mid_udf", 32'(underflow), 1);
        checkOutput("mid_busy", 32'(busy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("mid_rst_count", 32'(rd_count), 0);
        checkOutput("mid_rst_empty", 32'(empty), 1);
        checkOutput("mid_rst_busy", 32'(busy), 0);
        checkOutput("mid_rst_done", 32'(done), 0);
        checkOutput("mid_rst_ovf", 32'(overflow), 0);
        checkOutput("mid_rst_udf", 32'(underflow), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
